// File: rtl/mcu_test_sequencer.sv
// Test sequencer around the MCU core: loads ROM vectors into a local word RAM,
// lets the CPU work on them, then streams the results out to the verify RAM.
module mcu_test_sequencer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter int unsigned DATA_W    = 16,
  parameter bit          SIGN_EXT  = 1'b1,
  parameter int unsigned ROM_LAT   = 1,
  parameter logic [31:0] FINISH_PC = 32'h64,
  parameter int unsigned TIMEOUT   = 20'hFFFFF,
  parameter int unsigned CNT_W     = 20
) (
  input  logic              clk_sys,
  input  logic              rst_sync,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_rst,
  input  logic [31:0]       cpu_pc,
  input  logic [31:0]       cpu_mem_addr,
  input  logic              cpu_mem_we,
  input  logic [31:0]       cpu_mem_wdata,
  output logic [31:0]       cpu_mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_ADDR, S_LD_WAIT, S_LD_CAPT, S_RUN, S_WB, S_DONE, S_ERR
  } state_e;

  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        WAIT_LAST = 3'(ROM_LAT - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]       EXT_MASK  =
    (DATA_W >= 32) ? 32'h0 : ~((32'h1 << DATA_W) - 32'h1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [2:0]        wait_q, wait_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              ram_we_q, ram_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [31:0]       ext_rdata;
  logic [ADDR_W-1:0] cpu_idx;
  logic              cpu_in_range;
  logic              cnt_en;
  logic              unused_byte_lane;

  assign ext_rdata = (SIGN_EXT && rom_rdata[DATA_W-1]) ? (32'(rom_rdata) | EXT_MASK)
                                                       : 32'(rom_rdata);

  // Byte address -> word index; any set bit above the index is out of range.
  assign cpu_idx          = cpu_mem_addr[ADDR_W+1:2];
  assign cpu_in_range     = (cpu_mem_addr[31:ADDR_W+2] == '0);
  assign unused_byte_lane = ^cpu_mem_addr[1:0];

  assign cpu_mem_rdata = (state_q == S_RUN && cpu_in_range) ? mem_q[cpu_idx] : 32'h0;

  // NOTE: every variable gets a default at the top so no branch leaves one unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    run_cnt_d   = run_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = idx_q;
    mem_wdata   = ext_rdata;

    // Counting starts at the first capture, so the first vector's address/wait cycles are excluded.
    cnt_en = (state_q inside {S_LD_CAPT, S_RUN, S_WB}) ||
             ((state_q inside {S_LD_ADDR, S_LD_WAIT}) && idx_q != '0);
    if (cnt_en && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        state_d     = S_LD_ADDR;
        idx_d       = '0;
        run_cnt_d   = '0;
        cycle_cnt_d = '0;
      end
      S_LD_ADDR: begin
        state_d = S_LD_WAIT;
        wait_d  = '0;
      end
      S_LD_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_LD_CAPT;
        else                     wait_d  = wait_q + 3'd1;
      end
      S_LD_CAPT: begin
        mem_we = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d   = S_RUN;
          idx_d     = '0;
          run_cnt_d = '0;
        end else begin
          state_d = S_LD_ADDR;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (cpu_pc == FINISH_PC) begin
          state_d = S_WB;
          idx_d   = '0;
        end else if (run_cnt_q == RUN_LAST) begin
          state_d = S_ERR;
        end
        if (cpu_mem_we && cpu_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = cpu_idx;
          mem_wdata = cpu_mem_wdata;
        end
      end
      S_WB: begin
        if (idx_q == IDX_LAST) state_d = S_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_LD_ADDR;
          idx_d       = '0;
          run_cnt_d   = '0;
          cycle_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cpu_rst_d     = (state_d != S_RUN);
    ram_we_d      = (state_d == S_WB);
    busy_d        = (state_d inside {S_LD_ADDR, S_LD_WAIT, S_LD_CAPT, S_RUN, S_WB});
    done_d        = (state_d == S_DONE);
    timeout_err_d = (state_d == S_ERR);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or posedge rst_sync) begin
    if (rst_sync) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      wait_q        <= '0;
      run_cnt_q     <= '0;
      cycle_cnt_q   <= '0;
      cpu_rst_q     <= 1'b1;
      ram_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      wait_q        <= wait_d;
      run_cnt_q     <= run_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      cpu_rst_q     <= cpu_rst_d;
      ram_we_q      <= ram_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // NOTE: the word RAM has no reset; every word is rewritten by the load phase before the CPU sees it.
  always_ff @(posedge clk_sys) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rom_addr    = idx_q;
  assign ram_addr    = idx_q;
  assign ram_wdata   = mem_q[idx_q][DATA_W-1:0];
  assign ram_we      = ram_we_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_mcu_test_sequencer.sv
// Randomised bench for mcu_test_sequencer: two instances (sign-extend/ROM_LAT=1 and
// zero-extend/ROM_LAT=3 with a narrow saturating counter) checked against a vector model.
module tb_mcu_test_sequencer;
  localparam int          DEPTH = 4;
  localparam int          TMO   = 50;
  localparam logic [31:0] FIN   = 32'h64;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        rst_sync      [2];
  logic        start         [2];
  logic [1:0]  rom_addr      [2];
  logic [15:0] rom_rdata     [2];
  logic [1:0]  ram_addr      [2];
  logic        ram_we        [2];
  logic [15:0] ram_wdata     [2];
  logic        cpu_rst       [2];
  logic [31:0] cpu_pc        [2];
  logic [31:0] cpu_mem_addr  [2];
  logic        cpu_mem_we    [2];
  logic [31:0] cpu_mem_wdata [2];
  logic [31:0] cpu_mem_rdata [2];
  logic        busy          [2];
  logic        done          [2];
  logic        timeout_err   [2];
  logic [19:0] cycle_cnt     [2];
  logic [5:0]  cnt_narrow;

  logic [15:0] rom [2][DEPTH];
  logic [31:0] exp_mem [DEPTH];
  int          n_vec = 0;
  int          n_err = 0;
  int          cur_g = 0;

  mcu_test_sequencer #(.DEPTH(DEPTH), .DATA_W(16), .SIGN_EXT(1'b1), .ROM_LAT(1),
                       .FINISH_PC(FIN), .TIMEOUT(TMO), .CNT_W(20)) u_dut0 (
    .clk_sys(clk_sys), .rst_sync(rst_sync[0]), .start(start[0]),
    .rom_addr(rom_addr[0]), .rom_rdata(rom_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_wdata(ram_wdata[0]),
    .cpu_rst(cpu_rst[0]), .cpu_pc(cpu_pc[0]), .cpu_mem_addr(cpu_mem_addr[0]),
    .cpu_mem_we(cpu_mem_we[0]), .cpu_mem_wdata(cpu_mem_wdata[0]),
    .cpu_mem_rdata(cpu_mem_rdata[0]), .busy(busy[0]), .done(done[0]),
    .timeout_err(timeout_err[0]), .cycle_cnt(cycle_cnt[0]));

  mcu_test_sequencer #(.DEPTH(DEPTH), .DATA_W(16), .SIGN_EXT(1'b0), .ROM_LAT(3),
                       .FINISH_PC(FIN), .TIMEOUT(TMO), .CNT_W(6)) u_dut1 (
    .clk_sys(clk_sys), .rst_sync(rst_sync[1]), .start(start[1]),
    .rom_addr(rom_addr[1]), .rom_rdata(rom_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_wdata(ram_wdata[1]),
    .cpu_rst(cpu_rst[1]), .cpu_pc(cpu_pc[1]), .cpu_mem_addr(cpu_mem_addr[1]),
    .cpu_mem_we(cpu_mem_we[1]), .cpu_mem_wdata(cpu_mem_wdata[1]),
    .cpu_mem_rdata(cpu_mem_rdata[1]), .busy(busy[1]), .done(done[1]),
    .timeout_err(timeout_err[1]), .cycle_cnt(cnt_narrow));

  assign cycle_cnt[1] = {14'h0, cnt_narrow};

  // Test ROMs with 1- and 3-cycle read pipelines.
  logic [15:0] pipe0;
  logic [15:0] pipe1 [3];
  always @(posedge clk_sys) begin
    pipe0    <= rom[0][rom_addr[0]];
    pipe1[0] <= rom[1][rom_addr[1]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign rom_rdata[0] = pipe0;
  assign rom_rdata[1] = pipe1[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL i%0d %s: got 0x%0h, want 0x%0h", cur_g, tag, act, exp);
    end
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] ext_model(input int g, input logic [15:0] v);
    int s = int'(v);
    if (g == 0 && s >= 32768) s = s - 65536;
    return 32'(s);
  endfunction

  function automatic int exp_cycles(input int g, input int n_run, input bit wb);
    int lat  = lat_of(g);
    int cmax = (g == 0) ? 20'hFFFFF : 63;
    int c    = DEPTH * (lat + 2) - (lat + 1) + n_run + (wb ? DEPTH : 0);
    return (c > cmax) ? cmax : c;
  endfunction

  function automatic logic [31:0] rand_addr(output bit inr, output int idx);
    logic [31:0] a;
    idx = int'($urandom_range(0, DEPTH - 1));
    inr = ($urandom_range(0, 3) != 0);
    a   = (32'(idx) << 2) | 32'($urandom_range(0, 3));
    if (!inr) a = a | (32'h1 << $urandom_range(4, 31));
    return a;
  endfunction

  task automatic check_reset_vals(input int g);
    check("rst_busy", busy[g], 1'b0);
    check("rst_done", done[g], 1'b0);
    check("rst_terr", timeout_err[g], 1'b0);
    check("rst_cpu_rst", cpu_rst[g], 1'b1);
    check("rst_ram_we", ram_we[g], 1'b0);
    check("rst_cycle_cnt", cycle_cnt[g], 32'h0);
    check("rst_rom_addr", rom_addr[g], 32'h0);
    check("rst_ram_addr", ram_addr[g], 32'h0);
  endtask

  task automatic randomize_rom(input int g);
    for (int i = 0; i < DEPTH; i++)
      rom[g][i] = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
  endtask

  task automatic run_session(input int g, input int n_run, input bit expect_to,
                             input bit abort_wb, input bit pulse_start,
                             input bit poke_start, input bit directed);
    int lat = lat_of(g);
    int ld  = 0;
    int cyc = 0;
    int wb_n = 0;
    int hits [DEPTH];
    int limit;
    bit saw_we = 1'b0;
    cur_g = g;
    for (int i = 0; i < DEPTH; i++) begin
      hits[i]    = 0;
      exp_mem[i] = ext_model(g, rom[g][i]);
    end
    // The CPU keeps hammering word 0 and showing FINISH_PC while not running.
    cpu_pc[g]        = FIN;
    cpu_mem_addr[g]  = 32'h0;
    cpu_mem_wdata[g] = 32'hDEAD_BEEF;
    cpu_mem_we[g]    = 1'b1;
    if (pulse_start) begin
      start[g] = 1'b1;
      @(negedge clk_sys);
      start[g] = 1'b0;
    end
    while (cpu_rst[g] !== 1'b0 && cyc < 200) begin
      if (busy[g] === 1'b1) begin
        ld++;
        hits[rom_addr[g]]++;
        check("ld_rdata_zero", cpu_mem_rdata[g], 32'h0);
      end
      start[g] = poke_start && (ld == 3);
      @(negedge clk_sys);
      cyc++;
    end
    start[g] = 1'b0;
    check("ld_reached_run", 32'(cyc < 200), 32'h1);
    check("ld_cycles", ld, DEPTH * (lat + 2));
    for (int i = 0; i < DEPTH; i++) check("ld_addr_hold", hits[i], lat + 2);

    limit = expect_to ? TMO : n_run;
    for (int k = 0; k < limit; k++) begin
      bit          inr;
      bit          wr;
      int          idx;
      logic [31:0] exp_rd;
      check("run_cpu_rst", cpu_rst[g], 1'b0);
      check("run_ram_we", ram_we[g], 1'b0);
      if (!expect_to && k == limit - 1) cpu_pc[g] = FIN;
      else begin
        cpu_pc[g] = $urandom;
        if (cpu_pc[g] == FIN) cpu_pc[g] = 32'h0;
      end
      cpu_mem_wdata[g] = $urandom;
      if (directed && k < 3) begin
        idx              = 2;
        inr              = (k != 2);
        wr               = (k == 0);
        cpu_mem_addr[g]  = (k == 2) ? 32'h400 : 32'h8;
        cpu_mem_wdata[g] = 32'h1234;
      end else if (k == 0) begin
        idx             = 0;
        inr             = 1'b1;
        wr              = 1'b0;
        cpu_mem_addr[g] = 32'h0;
      end else begin
        cpu_mem_addr[g] = rand_addr(inr, idx);
        wr              = !directed && ($urandom_range(0, 1) == 1);
      end
      cpu_mem_we[g] = wr;
      #1;
      exp_rd = inr ? exp_mem[idx] : 32'h0;
      check("run_rdata", cpu_mem_rdata[g], exp_rd);
      if (wr && inr) exp_mem[idx] = cpu_mem_wdata[g];
      @(negedge clk_sys);
    end
    cpu_mem_we[g] = 1'b0;

    if (expect_to) begin
      check("to_err", timeout_err[g], 1'b1);
      check("to_done", done[g], 1'b0);
      check("to_busy", busy[g], 1'b0);
      check("to_cpu_rst", cpu_rst[g], 1'b1);
      for (int i = 0; i < 4; i++) begin
        if (ram_we[g] === 1'b1) saw_we = 1'b1;
        @(negedge clk_sys);
      end
      check("to_no_ram_we", saw_we, 1'b0);
      check("to_cycles", cycle_cnt[g], exp_cycles(g, TMO, 1'b0));
      return;
    end

    cyc = 0;
    while (ram_we[g] === 1'b1 && cyc < DEPTH + 4) begin
      check("wb_addr", ram_addr[g], wb_n);
      check("wb_data", ram_wdata[g], exp_mem[wb_n % DEPTH][15:0]);
      check("wb_busy", busy[g], 1'b1);
      if (abort_wb && wb_n == 2) begin
        rst_sync[g] = 1'b1;
        #1;
        check_reset_vals(g);
        @(negedge clk_sys);
        rst_sync[g] = 1'b0;
        return;
      end
      wb_n++;
      cyc++;
      @(negedge clk_sys);
    end
    check("wb_count", wb_n, DEPTH);
    check("done", done[g], 1'b1);
    check("done_busy", busy[g], 1'b0);
    check("done_cpu_rst", cpu_rst[g], 1'b1);
    check("done_terr", timeout_err[g], 1'b0);
    check("done_cycles", cycle_cnt[g], exp_cycles(g, n_run, 1'b1));
    cpu_mem_addr[g] = 32'h4;
    cpu_mem_we[g]   = 1'b1;
    #1;
    check("done_rdata_zero", cpu_mem_rdata[g], 32'h0);
    repeat (3) @(negedge clk_sys);
    cpu_mem_we[g] = 1'b0;
    check("done_hold", done[g], 1'b1);
    check("cycles_frozen", cycle_cnt[g], exp_cycles(g, n_run, 1'b1));
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_sync[g]      = 1'b1;
      start[g]         = 1'b0;
      cpu_pc[g]        = 32'h0;
      cpu_mem_addr[g]  = 32'h0;
      cpu_mem_we[g]    = 1'b0;
      cpu_mem_wdata[g] = 32'h0;
      for (int i = 0; i < DEPTH; i++) rom[g][i] = 16'h0;
    end
    repeat (3) @(negedge clk_sys);
    for (int g = 0; g < 2; g++) begin
      cur_g = g;
      check_reset_vals(g);
    end

    for (int g = 0; g < 2; g++) begin
      rom[g][0] = 16'h0003;
      rom[g][1] = 16'hFFFF;
      rom[g][2] = 16'h0007;
      rom[g][3] = 16'h8000;
      rst_sync[g] = 1'b0;
      run_session(g, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_session(g, 12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      run_session(g, TMO, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int r = 0; r < 4; r++) begin
        randomize_rom(g);
        run_session(g, int'($urandom_range(1, TMO)), 1'b0, 1'b0, 1'b1, (r % 2 == 1), 1'b0);
      end
      randomize_rom(g);
      run_session(g, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      randomize_rom(g);
      run_session(g, int'($urandom_range(5, 30)), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      randomize_rom(g);
      run_session(g, int'($urandom_range(1, TMO)), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
